alu74181_nibble_sequencer: RTL and testbench

Multi-cycle controller that runs one WIDTH-bit operation through a single external 4-bit ALU74181 slice, one nibble per clock, least-significant nibble first. The ripple carry and the A=B flag are held in registers between cycles. The block sits between the tile's input registers and the ALU74181 instance, and drives the slice's a/b/s/m/notc inputs. Handshake: start/busy/done.

---
 rtl/alu74181_nibble_sequencer_if.sv | 35 +++
 rtl/alu74181_nibble_sequencer.sv | 78 +++++++
 tb/tb_alu74181_nibble_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu74181_nibble_sequencer_if.sv
// alu74181_nibble_sequencer_if: tile-side handshake/operand bus and 74181 slice bus for the nibble sequencer.
interface alu74181_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             ena;
    logic             start;
    logic [3:0]       op_s;
    logic             op_m;
    logic             op_notc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_notc;
    logic [3:0]       alu_f;
    logic             alu_cout;
    logic             alu_eql;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout_n;
    logic             eql;
    logic             zero;
    // master is the surrounding tile together with the 74181 slice it owns
    modport master (
        output ena, start, op_s, op_m, op_notc, a, b, alu_f, alu_cout, alu_eql,
        input  alu_a, alu_b, alu_s, alu_m, alu_notc, busy, done, result, cout_n, eql, zero
    );
    modport slave (
        input  ena, start, op_s, op_m, op_notc, a, b, alu_f, alu_cout, alu_eql,
        output alu_a, alu_b, alu_s, alu_m, alu_notc, busy, done, result, cout_n, eql, zero
    );
endinterface

// File: rtl/alu74181_nibble_sequencer.sv
// alu74181_nibble_sequencer: runs one WIDTH-bit op through an external 4-bit 74181 slice,
// one nibble per clock LSB first, rippling carry and A=B through registers.
module alu74181_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic rst_n,
    alu74181_nibble_sequencer_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [3:0] s_q;
    logic m_q, carry, acc, done_q, cout_q, eql_q, last;
    logic [IW-1:0] idx;
    assign last = idx == IW'(NIBBLES - 1);
    always_comb begin
        next = state;
        next = (state == IDLE && bus.start) ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (bus.ena) state <= next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            m_q <= 1'b0;
            carry <= 1'b1;
            acc <= 1'b0;
            idx <= '0;
            result_q <= '0;
            done_q <= 1'b0;
            cout_q <= 1'b1;
            eql_q <= 1'b0;
        end else if (bus.ena) begin
            done_q <= state == DONE;
            if (state == IDLE && bus.start) begin
                a_q <= bus.a;
                b_q <= bus.b;
                s_q <= bus.op_s;
                m_q <= bus.op_m;
                carry <= bus.op_notc;
                acc <= 1'b1;
                idx <= '0;
                result_q <= '0;
            end
            if (state == RUN) begin
                result_q[4*idx +: 4] <= bus.alu_f;
                carry <= bus.alu_cout;
                acc <= acc & bus.alu_eql;
                idx <= last ? '0 : idx + 1'b1;
            end
            // flags are captured once so a later start leaves them untouched
            if (state == DONE) begin
                cout_q <= carry;
                eql_q <= acc;
            end
        end
    end
    assign bus.alu_a = a_q[4*idx +: 4];
    assign bus.alu_b = b_q[4*idx +: 4];
    assign bus.alu_s = s_q;
    assign bus.alu_m = m_q;
    assign bus.alu_notc = carry;
    assign bus.busy = state == RUN;
    assign bus.done = done_q;
    assign bus.result = result_q;
    assign bus.cout_n = cout_q;
    assign bus.eql = eql_q;
    assign bus.zero = ~|result_q;
endmodule

// File: tb/tb_alu74181_nibble_sequencer.sv
// tb_alu74181_nibble_sequencer: gate-level 74181 slice stub, word-level reference model,
// and a scoreboard monitor checking every done pulse.
module tb_alu74181_nibble_sequencer;
    logic clk, rst_n;
    int n_cmp = 0, n_err = 0;
    typedef struct packed {logic [15:0] r; logic c; logic e; logic z;} exp_t;
    exp_t q[$];
    logic notc_seen[16];
    logic done_d = 1'b0;

    alu74181_nibble_sequencer_if #(.WIDTH(16)) bus ();
    alu74181_nibble_sequencer #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74181 slice with active-high data: per-bit generate/propagate and ripple carry
    function automatic logic [5:0] slice74181(input logic [3:0] a, b, s, input logic m, notc);
        logic [3:0] g, p, f;
        logic c;
        c = ~notc;
        for (int i = 0; i < 4; i++) begin
            g[i] = (a[i] & b[i] & s[3]) | (a[i] & ~b[i] & s[2]);
            p[i] = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
            f[i] = m ? ~(g[i] ^ p[i]) : (g[i] ^ p[i] ^ c);
            c = g[i] | (p[i] & c);
        end
        return {~c, &f, f};
    endfunction

    always_comb {bus.alu_cout, bus.alu_eql, bus.alu_f} =
        slice74181(bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_notc);

    // whole-word function table: arithmetic is X + Y + carry-in, logic is bitwise
    function automatic exp_t ref_model(input logic [3:0] s, input logic m, notc, input logic [15:0] a, b);
        logic [15:0] x, y, lg;
        logic [16:0] sum;
        exp_t e;
        case (s)
            4'h0: begin x = a; y = 16'h0; lg = ~a; end
            4'h1: begin x = a | b; y = 16'h0; lg = ~(a | b); end
            4'h2: begin x = a | ~b; y = 16'h0; lg = ~a & b; end
            4'h3: begin x = 16'h0; y = 16'hFFFF; lg = 16'h0; end
            4'h4: begin x = a; y = a & ~b; lg = ~(a & b); end
            4'h5: begin x = a | b; y = a & ~b; lg = ~b; end
            4'h6: begin x = a; y = ~b; lg = a ^ b; end
            4'h7: begin x = a & ~b; y = 16'hFFFF; lg = a & ~b; end
            4'h8: begin x = a; y = a & b; lg = ~a | b; end
            4'h9: begin x = a; y = b; lg = ~(a ^ b); end
            4'hA: begin x = a | ~b; y = a & b; lg = b; end
            4'hB: begin x = a & b; y = 16'hFFFF; lg = a & b; end
            4'hC: begin x = a; y = a; lg = 16'hFFFF; end
            4'hD: begin x = a | b; y = a; lg = a | ~b; end
            4'hE: begin x = a | ~b; y = a; lg = a | b; end
            default: begin x = a; y = 16'hFFFF; lg = a; end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {16'h0, ~notc};
        e.r = m ? lg : sum[15:0];
        e.c = ~sum[16];
        e.e = &e.r;
        e.z = e.r == 16'h0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done && !done_d) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no pending op");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_result", bus.result, e.r);
                chk("sb_cout_n", bus.cout_n, e.c);
                chk("sb_eql", bus.eql, e.e);
                chk("sb_zero", bus.zero, e.z);
            end
        end
        done_d = rst_n && bus.done;
    end

    task automatic issue(input logic [3:0] s, input logic m, notc, input logic [15:0] a, b,
                         input int stall_at, glitch_at);
        int k, nb, stalled;
        stalled = stall_at > 0;
        @(negedge clk);
        bus.op_s = s; bus.op_m = m; bus.op_notc = notc; bus.a = a; bus.b = b;
        bus.start = 1'b1;
        q.push_back(ref_model(s, m, notc, a, b));
        k = 0;
        nb = 0;
        do begin
            @(negedge clk);
            k++;
            if (bus.busy) begin
                nb++;
                if (nb <= 16) notc_seen[nb-1] = bus.alu_notc;
            end
            bus.start = k == glitch_at;
            if (k == glitch_at) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
                bus.op_s = 4'($urandom);
            end
            bus.ena = !(stalled && k >= stall_at && k < stall_at + 3);
        end while (!bus.done && k < 40);
        bus.ena = 1'b1;
        bus.start = 1'b0;
        chk("latency", k - 1, 5 + 3 * stalled);
        chk("busy_cycles", nb, 4 + 3 * stalled);
    endtask

    initial begin
        int seen_busy;
        logic [15:0] held;
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.start = 1'b0;
        bus.op_s = 4'h0; bus.op_m = 1'b0; bus.op_notc = 1'b1; bus.a = 16'h0; bus.b = 16'h0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_cout_n", bus.cout_n, 1);
        chk("rst_eql", bus.eql, 0);
        chk("rst_zero", bus.zero, 1);
        chk("rst_alu_notc", bus.alu_notc, 1);
        @(negedge clk) rst_n = 1'b1;

        issue(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FCD, 0, 0);
        chk("add_result", bus.result, 16'h2201);
        chk("add_cout_n", bus.cout_n, 1);
        chk("add_zero", bus.zero, 0);
        issue(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 0, 0);
        chk("ripple_result", bus.result, 16'h0000);
        chk("ripple_cout_n", bus.cout_n, 0);
        chk("ripple_zero", bus.zero, 1);
        for (int i = 1; i < 4; i++) chk($sformatf("ripple_notc_nib%0d", i), notc_seen[i], 0);
        issue(4'b0110, 1'b0, 1'b0, 16'h5000, 16'h0001, 0, 0);
        chk("sub_result", bus.result, 16'h4FFF);
        chk("sub_cout_n", bus.cout_n, 0);
        issue(4'b0110, 1'b0, 1'b0, 16'h0001, 16'h0002, 0, 0);
        chk("sub_borrow_result", bus.result, 16'hFFFF);
        chk("sub_borrow_cout_n", bus.cout_n, 1);
        issue(4'b0110, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 0, 0);
        chk("cmp_eq_result", bus.result, 16'hFFFF);
        chk("cmp_eq_eql", bus.eql, 1);
        issue(4'b0110, 1'b0, 1'b1, 16'hBEEF, 16'hBEEE, 0, 0);
        chk("cmp_ne_result", bus.result, 16'h0000);
        chk("cmp_ne_eql", bus.eql, 0);
        issue(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 0, 2);
        chk("xor_glitch_result", bus.result, 16'h0FF0);

        // a start landing in the DONE state must not launch a second op
        issue(4'b1001, 1'b0, 1'b1, 16'h0102, 16'h0304, 0, 5);
        held = bus.result;
        seen_busy = 0;
        repeat (8) @(negedge clk) if (bus.busy) seen_busy++;
        chk("start_in_done_ignored", seen_busy, 0);
        chk("result_held", bus.result, held);

        @(negedge clk);
        bus.op_s = 4'b1001; bus.op_m = 1'b0; bus.op_notc = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FCD, 0, 0);
        chk("post_abort_result", bus.result, 16'h2201);
        issue(4'b1001, 1'b0, 1'b1, 16'hA5A5, 16'h1357, 2, 0);
        chk("stall_result", bus.result, 16'hB8FC);

        for (int n = 0; n < 40; n++)
            issue(4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
